// File: rtl/udp_tx_packer.sv
// udp_tx_packer: ping-pong payload buffer in front of a UDP sender.
// The write side fills one bank while the read FSM hands the other bank to
// the sender. Bytes that arrive while both banks are full are dropped and counted.
module udp_tx_packer #(
    parameter logic [15:0] PAYLOAD_LEN = 16'd512,
    parameter int          ADDR_W      = 10
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_wr,
    input  logic [7:0]  i_wr_data,
    input  logic        i_flush,
    output logic        o_full,
    output logic [7:0]  o_data,
    output logic [15:0] o_data_len,
    input  logic        i_rd,
    output logic        o_enable,
    input  logic        i_ready,
    output logic        o_busy,
    output logic        o_overflow,
    output logic [15:0] o_drop_cnt
);

    localparam int DEPTH = 2 ** ADDR_W;

    typedef enum logic [2:0] {
        RD_IDLE,
        RD_ARM,
        RD_START,
        RD_WAIT_BUSY,
        RD_WAIT_DONE
    } rd_state_t;

    // Both banks live in one array; the bank select is the top address bit.
    logic [7:0]        mem [0:2*DEPTH-1];
    logic [1:0]        full;
    logic [1:0][15:0]  bank_len;
    logic              wr_bank;
    logic              rd_bank;
    logic [15:0]       wr_cnt;
    logic [15:0]       rd_ptr;
    rd_state_t         rd_state;

    logic              wr_accept;
    logic              wr_drop;
    logic [15:0]       wr_cnt_next;
    logic              close_bank;
    logic              release_bank;
    logic [1:0]        full_set;
    logic [1:0]        full_clr;
    logic              rd_adv;
    logic [15:0]       rd_ptr_next;
    logic [7:0]        rd_fetch;

    assign o_full = full[wr_bank];

    // Write-side and release decode: accept/drop, bank close, full-flag set/clear masks.
    always_comb begin
        // NOTE: every signal assigned here gets a default first so no latch is inferred.
        wr_accept    = i_wr && !full[wr_bank];
        wr_drop      = i_wr && full[wr_bank];
        wr_cnt_next  = wr_cnt + 16'(wr_accept);
        // A byte written alongside i_flush is counted before the close decision.
        close_bank   = (wr_cnt_next == PAYLOAD_LEN) || (i_flush && (wr_cnt_next != 16'd0));
        release_bank = (rd_state == RD_WAIT_DONE) && i_ready;
        full_set     = 2'b00;
        full_clr     = 2'b00;
        if (close_bank)   full_set[wr_bank] = 1'b1;
        if (release_bank) full_clr[rd_bank] = 1'b1;
    end

    // Read-pointer advance and prefetch of the byte o_data shows next cycle.
    always_comb begin
        rd_adv      = i_rd && (rd_state != RD_IDLE) && (rd_ptr != o_data_len);
        rd_ptr_next = rd_ptr + 16'(rd_adv);
        rd_fetch    = 8'h00;
        if (rd_ptr_next < o_data_len)
            rd_fetch = mem[{rd_bank, rd_ptr_next[ADDR_W-1:0]}];
    end

    // Payload storage; write port only.
    always_ff @(posedge clk) begin
        // NOTE: the memory has no reset; stale bytes are unreachable once the full flags clear.
        if (wr_accept)
            mem[{wr_bank, wr_cnt[ADDR_W-1:0]}] <= i_wr_data;
    end

    // Write side: fill counter, bank switch, full flags, lengths and drop statistics.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (!rst_n) begin
            wr_bank    <= 1'b0;
            wr_cnt     <= 16'd0;
            full       <= 2'b00;
            bank_len   <= '0;
            o_overflow <= 1'b0;
            o_drop_cnt <= 16'd0;
        end else begin
            // Close of one bank and release of the other are independent.
            full <= (full & ~full_clr) | full_set;
            if (close_bank) begin
                bank_len[wr_bank] <= wr_cnt_next;
                wr_bank           <= ~wr_bank;
                wr_cnt            <= 16'd0;
            end else begin
                wr_cnt <= wr_cnt_next;
            end
            if (wr_drop) begin
                o_overflow <= 1'b1;
                if (o_drop_cnt != 16'hFFFF)
                    o_drop_cnt <= o_drop_cnt + 16'd1;
            end
        end
    end

    // Read FSM: hand a full bank to the sender, stream it out, release on sender done.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_state   <= RD_IDLE;
            rd_bank    <= 1'b0;
            rd_ptr     <= 16'd0;
            o_enable   <= 1'b0;
            o_busy     <= 1'b0;
            o_data     <= 8'h00;
            o_data_len <= 16'd0;
        end else begin
            // Outside RD_IDLE the pointer and prefetched byte track i_rd every cycle.
            if (rd_state != RD_IDLE) begin
                rd_ptr <= rd_ptr_next;
                o_data <= rd_fetch;
            end
            case (rd_state)
                RD_IDLE: begin
                    o_data <= 8'h00;
                    if (full[rd_bank]) begin
                        rd_ptr     <= 16'd0;
                        o_data_len <= bank_len[rd_bank];
                        o_data     <= mem[{rd_bank, {ADDR_W{1'b0}}}];
                        rd_state   <= RD_ARM;
                    end
                end
                RD_ARM: begin
                    if (i_ready) begin
                        o_enable <= 1'b1;
                        o_busy   <= 1'b1;
                        rd_state <= RD_START;
                    end
                end
                RD_START: begin
                    o_enable <= 1'b0;
                    rd_state <= RD_WAIT_BUSY;
                end
                RD_WAIT_BUSY: begin
                    if (!i_ready)
                        rd_state <= RD_WAIT_DONE;
                end
                RD_WAIT_DONE: begin
                    if (i_ready) begin
                        rd_bank  <= ~rd_bank;
                        rd_ptr   <= 16'd0;
                        o_data   <= 8'h00;
                        o_busy   <= 1'b0;
                        rd_state <= RD_IDLE;
                    end
                end
                default: rd_state <= RD_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_udp_tx_packer.sv
// Self-checking bench for udp_tx_packer: writer pushes expected bytes and
// packet lengths to queues; a sender model pops and compares them on readout.
module tb_udp_tx_packer;

    localparam int PL = 512;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        i_wr = 1'b0;
    logic [7:0]  i_wr_data = 8'h00;
    logic        i_flush = 1'b0;
    logic        o_full;
    logic [7:0]  o_data;
    logic [15:0] o_data_len;
    logic        i_rd = 1'b0;
    logic        o_enable;
    logic        i_ready = 1'b1;
    logic        o_busy;
    logic        o_overflow;
    logic [15:0] o_drop_cnt;

    udp_tx_packer #(.PAYLOAD_LEN(16'd512), .ADDR_W(10)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_wr       (i_wr),
        .i_wr_data  (i_wr_data),
        .i_flush    (i_flush),
        .o_full     (o_full),
        .o_data     (o_data),
        .o_data_len (o_data_len),
        .i_rd       (i_rd),
        .o_enable   (o_enable),
        .i_ready    (i_ready),
        .o_busy     (o_busy),
        .o_overflow (o_overflow),
        .o_drop_cnt (o_drop_cnt)
    );

    always #5 clk = ~clk;

    int         n_vec = 0;
    int         n_err = 0;
    int         en_cnt = 0;
    int         m_cnt = 0;
    bit         sender_on = 1'b1;
    bit         sender_busy = 1'b0;
    logic [7:0] exp_q [$];
    int         len_q [$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Count start pulses, sampled on the falling edge.
    always @(negedge clk) if (o_enable === 1'b1) en_cnt++;

    task automatic check_reset_state(input string pfx);
        check({pfx, "_enable"},   o_enable,   0);
        check({pfx, "_busy"},     o_busy,     0);
        check({pfx, "_full"},     o_full,     0);
        check({pfx, "_overflow"}, o_overflow, 0);
        check({pfx, "_drop_cnt"}, o_drop_cnt, 0);
        check({pfx, "_data"},     o_data,     0);
        check({pfx, "_data_len"}, o_data_len, 0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        exp_q.delete();
        len_q.delete();
        m_cnt = 0;
    endtask

    // Accepted write: waits for o_full low, then records the byte and any closed packet.
    task automatic put(input logic [7:0] b, input bit flush);
        int guard = 0;
        while (o_full && guard < 5000) begin
            @(negedge clk);
            guard++;
        end
        if (o_full) check("wr_stall", o_full, 0);
        i_wr      = 1'b1;
        i_wr_data = b;
        i_flush   = flush;
        exp_q.push_back(b);
        m_cnt++;
        if (m_cnt == PL || flush) begin
            len_q.push_back(m_cnt);
            m_cnt = 0;
        end
        @(negedge clk);
        i_wr    = 1'b0;
        i_flush = 1'b0;
    endtask

    task automatic flush_only();
        i_flush = 1'b1;
        if (m_cnt > 0) begin
            len_q.push_back(m_cnt);
            m_cnt = 0;
        end
        @(negedge clk);
        i_flush = 1'b0;
    endtask

    // Unchecked write used when the bench deliberately overruns the buffer.
    task automatic raw_wr(input logic [7:0] b, input bit flush);
        i_wr      = 1'b1;
        i_wr_data = b;
        i_flush   = flush;
        @(negedge clk);
        i_wr    = 1'b0;
        i_flush = 1'b0;
    endtask

    task automatic drain(input string tag);
        int n = 0;
        while ((exp_q.size() != 0 || len_q.size() != 0 || sender_busy || o_busy) && n < 5000) begin
            @(negedge clk);
            n++;
        end
        check(tag, (exp_q.size() == 0 && len_q.size() == 0 && !o_busy), 1);
    endtask

    // Sender model: on o_enable read every byte with i_ready high, probe past
    // the end, then drop i_ready for one cycle to signal completion.
    task automatic sender();
        int         len;
        logic [7:0] eb;
        forever begin
            @(negedge clk);
            if (sender_on && o_enable) begin
                sender_busy = 1'b1;
                check("busy_at_enable", o_busy, 1);
                if (len_q.size() == 0) begin
                    check("unexpected_pkt", len_q.size(), 1);
                    len = int'(o_data_len);
                end else begin
                    len = len_q.pop_front();
                    check("data_len", o_data_len, len);
                end
                for (int k = 0; k < len; k++) begin
                    if (exp_q.size() == 0) begin
                        check("byte_underflow", exp_q.size(), 1);
                        eb = 8'h00;
                    end else begin
                        eb = exp_q.pop_front();
                    end
                    check("rd_byte", o_data, eb);
                    i_rd = 1'b1;
                    @(negedge clk);
                end
                check("tail_zero", o_data, 0);
                @(negedge clk);
                i_rd = 1'b0;
                check("tail_hold", o_data, 0);
                i_ready = 1'b0;
                @(negedge clk);
                i_ready = 1'b1;
                @(negedge clk);
                check("released", o_busy, 0);
                sender_busy = 1'b0;
            end
        end
    endtask

    initial begin
        #600000;
        $display("FAIL watchdog: simulation did not finish, %0d miscompares so far", n_err);
        $fatal(1);
    end

    initial begin
        int en_base;
        int n;
        fork
            sender();
        join_none

        // Reset state
        do_reset();
        check_reset_state("rst");

        // Full 512-byte packet, pattern 0..255,0..255
        en_base = en_cnt;
        for (int i = 0; i < 512; i++) put(8'(i), 1'b0);
        drain("drain_512");
        check("pulses_512", en_cnt - en_base, 1);

        // Short packet closed by flush
        en_base = en_cnt;
        for (int i = 0; i < 10; i++) put(8'(8'h40 + i), 1'b0);
        flush_only();
        drain("drain_10");
        check("pulses_10", en_cnt - en_base, 1);

        // Flush with an empty bank does nothing
        en_base = en_cnt;
        flush_only();
        repeat (20) @(negedge clk);
        check("pulses_empty_flush", en_cnt - en_base, 0);
        check("busy_empty_flush", o_busy, 0);

        // Flush and write in the same cycle: byte included in the packet
        en_base = en_cnt;
        for (int i = 0; i < 3; i++) put(8'(8'h11 * (i + 1)), 1'b0);
        put(8'hAB, 1'b1);
        drain("drain_4");
        check("pulses_4", en_cnt - en_base, 1);

        // Back-to-back banks: full bank then partial bank
        en_base = en_cnt;
        for (int i = 0; i < 532; i++) put(8'($urandom_range(0, 255)), 1'b0);
        flush_only();
        drain("drain_two");
        check("pulses_two", en_cnt - en_base, 2);
        check("no_drop", o_drop_cnt, 0);
        check("no_overflow", o_overflow, 0);

        // Overrun with sender stalled: 1100 writes into 2x512 of space
        sender_on = 1'b0;
        i_ready   = 1'b0;
        for (int i = 0; i < 1100; i++) raw_wr(8'(i), 1'b0);
        check("ovf_full", o_full, 1);
        check("ovf_drop_cnt", o_drop_cnt, 76);
        check("ovf_flag", o_overflow, 1);
        do_reset();
        check_reset_state("rst_ovf");

        // Reset while the read FSM waits for the sender to finish
        i_ready = 1'b1;
        for (int i = 0; i < 5; i++) raw_wr(8'(i), i == 4);
        n = 0;
        while (!o_enable && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("enable_seen", o_enable, 1);
        i_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("busy_wait_done", o_busy, 1);
        rst_n = 1'b0;
        @(negedge clk);
        check_reset_state("rst_mid");
        rst_n   = 1'b1;
        i_ready = 1'b1;
        exp_q.delete();
        len_q.delete();
        m_cnt = 0;
        @(negedge clk);
        sender_on = 1'b1;

        // Fresh fill after the mid-packet reset
        en_base = en_cnt;
        for (int i = 0; i < 512; i++) put(8'(255 - (i % 256)), 1'b0);
        drain("drain_after_rst");
        check("pulses_after_rst", en_cnt - en_base, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/udp_tx_packer.md
UDP_TX_PACKER -- requirements
Module: udp_tx_packer

Interface
REQ-001 Parameter PAYLOAD_LEN, default 16'd512: bytes per full packet; legal range 1..1024.
REQ-002 Parameter ADDR_W, default 10: bank address width; each bank holds 2**ADDR_W bytes.
REQ-003 clk  input  1  single clock; all logic on the rising edge.
REQ-004 rst_n  input  1  reset; synchronous, active-low.
REQ-005 i_wr  input  1  write strobe; one payload byte per cycle while high.
REQ-006 i_wr_data  input  8  payload byte.
REQ-007 i_flush  input  1  close the partially filled bank and send it.
REQ-008 o_full  output  1  high when a write in this cycle would be dropped.
REQ-009 o_data  output  8  payload byte to the UDP sender.
REQ-010 o_data_len  output  16  byte count of the bank being sent.
REQ-011 i_rd  input  1  sender read strobe; advances o_data.
REQ-012 o_enable  output  1  start pulse to the sender.
REQ-013 i_ready  input  1  sender idle/ready flag.
REQ-014 o_busy  output  1  high from o_enable until the bank is released.
REQ-015 o_overflow  output  1  sticky flag: at least one byte dropped.
REQ-016 o_drop_cnt  output  16  dropped-byte count; saturates at 16'hFFFF.

Function
REQ-017 Storage: two banks (ping-pong); each bank has a full flag and a 16-bit length register.
REQ-018 Write side: wr_bank, wr_cnt; an accepted i_wr stores the byte at bank[wr_bank][wr_cnt] and increments wr_cnt.
REQ-019 Close: when wr_cnt reaches PAYLOAD_LEN, or on i_flush with wr_cnt>0, the block sets that bank's full flag and latches length=wr_cnt, toggles wr_bank, and clears wr_cnt in the same cycle.
REQ-020 When i_flush and i_wr occur in the same cycle, the byte is stored first and the bank closes with length including it.
REQ-021 When i_flush occurs with wr_cnt==0, the block ignores it.
REQ-022 o_full = full flag of the current wr_bank. When i_wr occurs with o_full high, the byte is dropped, o_overflow sets, and o_drop_cnt increments.
REQ-023 Read FSM states: RD_IDLE, RD_ARM, RD_START, RD_WAIT_BUSY, RD_WAIT_DONE.
REQ-024 RD_IDLE: when bank rd_bank is full, the FSM loads rd_ptr=0, drives o_data_len = that bank's length, and goes to RD_ARM.
REQ-025 RD_ARM: when i_ready==1, goes to RD_START.
REQ-026 RD_START: o_enable=1 for exactly one cycle, then goes to RD_WAIT_BUSY.
REQ-027 RD_WAIT_BUSY: when i_ready==0, goes to RD_WAIT_DONE.
REQ-028 RD_WAIT_DONE: when i_ready==1, the FSM clears rd_bank's full flag, toggles rd_bank, and goes to RD_IDLE.
REQ-029 o_busy is high in RD_START, RD_WAIT_BUSY and RD_WAIT_DONE.
REQ-030 o_data shows bank[rd_bank][rd_ptr] from RD_ARM onward.
REQ-031 Each i_rd increments rd_ptr, and the next byte is valid on o_data the cycle after i_rd; this latency is met with a prefetch register.
REQ-032 i_rd beyond o_data_len bytes holds rd_ptr at o_data_len and o_data at 8'h00.
REQ-033 Releasing bank X and closing bank Y in the same cycle are independent; both take effect.
REQ-034 When writing wraps onto the bank currently being read, o_full stays high until RD_WAIT_DONE releases it.
REQ-035 o_data_len is stable from RD_IDLE exit until release.
REQ-036 Bytes leave in the same order they were written; no reordering across banks.

Reset
REQ-037 With rst_n==0 at a clock edge: both full flags clear, wr_bank=rd_bank=0, wr_cnt=rd_ptr=0, read FSM=RD_IDLE.
REQ-038 Reset values of outputs: o_enable=0, o_busy=0, o_full=0, o_overflow=0, o_drop_cnt=0, o_data=8'h00, o_data_len=0.
REQ-039 Reset mid-packet discards all buffered data; memory contents need not clear.

Verification
REQ-040 Write 512 bytes 0..255,0..255 with i_ready=1 and a sender model -> one o_enable pulse, o_data_len=512, bytes read back in order.
REQ-041 Write 10 bytes, then i_flush -> o_data_len=10, o_enable pulse; i_flush with empty bank -> no pulse.
REQ-042 Hold i_ready=0 and write 1100 bytes (PAYLOAD_LEN=512) -> both banks full, o_full=1, 76 bytes dropped, o_drop_cnt=76, o_overflow=1.
REQ-043 i_flush plus i_wr of 0xAB in the same cycle after 3 bytes -> o_data_len=4, last byte 0xAB.
REQ-044 Assert rst_n=0 while in RD_WAIT_DONE -> next cycle all outputs at reset values, and the next 512-byte fill starts from bank 0.
REQ-045 Sender model pulses i_ready low for 1 cycle, then high -> bank released exactly once, and the second bank is sent without gap errors.
